// File: rtl/rom_ram_copy_engine_pkg.sv
// Shared types and constants for the ROM-to-RAM block copier.
// Holds the FSM state encoding and the legal ROM latency range.
package rom_ram_copy_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int ROM_LAT_MIN = 1;
    localparam int ROM_LAT_MAX = 4;

endpackage

// File: rtl/rom_ram_copy_engine_if.sv
// Control, ROM-read and RAM-write signals of the block copier.
// The engine uses the slave side; the controller, ROM and RAM use the master side.
interface rom_ram_copy_engine_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              start_sig;
    logic [ADDR_W-1:0] src_base;
    logic [ADDR_W-1:0] dst_base;
    logic [ADDR_W:0]   length;
    logic              busy;
    logic              done_sig;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data_in;
    logic              write_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;

    modport master (
        output start_sig, src_base, dst_base, length, rom_data_in,
        input  busy, done_sig, rom_addr, write_en, ram_addr, ram_data
    );

    modport slave (
        input  start_sig, src_base, dst_base, length, rom_data_in,
        output busy, done_sig, rom_addr, write_en, ram_addr, ram_data
    );
endinterface

// File: rtl/rom_ram_copy_engine_align_pipe.sv
// DEPTH-stage shift register carrying an issue-valid bit and a RAM address,
// so the write strobe lines up with data returning from a latency-DEPTH ROM.
module rom_ram_copy_engine_align_pipe #(
    parameter int DEPTH  = 1,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              pending_o
);

    logic [DEPTH-1:0]  valid_q;
    logic [ADDR_W-1:0] addr_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= valid_i;
            addr_q[0]  <= addr_i;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                addr_q[i]  <= addr_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign addr_o  = addr_q[DEPTH-1];

    // Words still travelling ahead of the output stage; the last write is
    // happening once only the final stage can be valid.
    if (DEPTH > 1) begin : g_pend
        assign pending_o = |valid_q[DEPTH-2:0];
    end else begin : g_nopend
        assign pending_o = 1'b0;
    end

endmodule

// File: rtl/rom_ram_copy_engine.sv
// ROM-to-RAM block copier: issues one ROM read per cycle over a programmable
// window and writes the returning data to RAM through an alignment pipeline.
module rom_ram_copy_engine
    import rom_ram_copy_engine_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int ROM_LAT = 1
) (
    input logic                  clk,
    input logic                  rst_n,
    rom_ram_copy_engine_if.slave bus
);

    localparam int LAT = (ROM_LAT < ROM_LAT_MIN) ? ROM_LAT_MIN :
                         (ROM_LAT > ROM_LAT_MAX) ? ROM_LAT_MAX : ROM_LAT;
    localparam logic [ADDR_W:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W:0]   remain_q, remain_d;
    logic [ADDR_W:0]   len_clamped;
    logic              pipe_valid;
    logic [ADDR_W-1:0] pipe_addr;
    logic              pipe_pending;
    logic [DATA_W-1:0] ram_data_w;

    assign len_clamped = (bus.length > FULL_LEN) ? FULL_LEN : bus.length;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rom_addr_q <= '0;
            dst_q      <= '0;
            remain_q   <= '0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            dst_q      <= dst_d;
            remain_q   <= remain_d;
        end
    end

    // rom_addr stops on the last issued address so it holds outside READ.
    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        dst_d      = dst_q;
        remain_d   = remain_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start_sig) begin
                    if (len_clamped == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d    = ST_READ;
                        rom_addr_d = bus.src_base;
                        dst_d      = bus.dst_base;
                        remain_d   = len_clamped;
                    end
                end
            end
            ST_READ: begin
                dst_d    = dst_q + ADDR_W'(1);
                remain_d = remain_q - (ADDR_W+1)'(1);
                if (remain_q == (ADDR_W+1)'(1)) begin
                    state_d = ST_DRAIN;
                end else begin
                    rom_addr_d = rom_addr_q + ADDR_W'(1);
                end
            end
            ST_DRAIN: begin
                if (!pipe_pending) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    rom_ram_copy_engine_align_pipe #(
        .DEPTH  (LAT),
        .ADDR_W (ADDR_W)
    ) u_align_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_i   (state_q == ST_READ),
        .addr_i    (dst_q),
        .valid_o   (pipe_valid),
        .addr_o    (pipe_addr),
        .pending_o (pipe_pending)
    );

    assign ram_data_w   = bus.rom_data_in;
    assign bus.ram_data = ram_data_w;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done_sig = (state_q == ST_DONE);
    assign bus.rom_addr = rom_addr_q;
    assign bus.write_en = pipe_valid;
    assign bus.ram_addr = pipe_addr;

endmodule

// File: tb/tb_rom_ram_copy_engine.sv
// Directed bench for rom_ram_copy_engine: a ROM_LAT=1 and a ROM_LAT=3 instance,
// each fed by a behavioural ROM holding A0+i at address i.
module tb_rom_ram_copy_engine;

    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    logic [7:0] rom [16];
    logic [7:0] d3_a, d3_b;

    int wr_cyc  [$];
    int wr_addr [$];
    int wr_data [$];
    int rd_addr [$];
    int done_cyc;
    int done_count;
    int busy_after;

    rom_ram_copy_engine_if #(.DATA_W(8), .ADDR_W(4)) if1 ();
    rom_ram_copy_engine_if #(.DATA_W(8), .ADDR_W(4)) if3 ();

    rom_ram_copy_engine #(.DATA_W(8), .ADDR_W(4), .ROM_LAT(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    rom_ram_copy_engine #(.DATA_W(8), .ADDR_W(4), .ROM_LAT(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 16; i++) begin
            rom[i] = 8'hA0 + 8'(i);
        end
    end

    // Synchronous ROM models: latency 1 and latency 3.
    always @(posedge clk) begin
        if1.rom_data_in <= rom[if1.rom_addr];
        d3_a            <= rom[if3.rom_addr];
        d3_b            <= d3_a;
        if3.rom_data_in <= d3_b;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)",
                     tag, observed, observed, expected, expected);
        end
    endtask

    task automatic driveStart(input int sel, input logic s, input int src, input int dst, input int len);
        if (sel == 1) begin
            if1.start_sig = s;
            if1.src_base  = 4'(src);
            if1.dst_base  = 4'(dst);
            if1.length    = 5'(len);
        end else begin
            if3.start_sig = s;
            if3.src_base  = 4'(src);
            if3.dst_base  = 4'(dst);
            if3.length    = 5'(len);
        end
    endtask

    // Called just after a negedge; cycle i is sampled at the i-th negedge after edge T.
    task automatic applyStimulus(input int sel, input int src, input int dst, input int len,
                                 input int pulse_at, input int budget);
        logic we, dn, bz;
        int   ad, da, ra;
        wr_cyc.delete();
        wr_addr.delete();
        wr_data.delete();
        rd_addr.delete();
        done_cyc   = -1;
        done_count = 0;
        busy_after = 1;
        driveStart(sel, 1'b1, src, dst, len);
        @(posedge clk);
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (sel == 1) begin
                we = if1.write_en; dn = if1.done_sig; bz = if1.busy;
                ad = int'(if1.ram_addr); da = int'(if1.ram_data); ra = int'(if1.rom_addr);
            end else begin
                we = if3.write_en; dn = if3.done_sig; bz = if3.busy;
                ad = int'(if3.ram_addr); da = int'(if3.ram_data); ra = int'(if3.rom_addr);
            end
            if (we) begin
                wr_cyc.push_back(i);
                wr_addr.push_back(ad);
                wr_data.push_back(da);
            end
            if (i <= len) rd_addr.push_back(ra);
            if (dn) begin
                done_count++;
                if (done_cyc < 0) done_cyc = i;
            end
            if (i == 1) driveStart(sel, 1'b0, src, dst, len);
            if (pulse_at > 0 && i == pulse_at) driveStart(sel, 1'b1, (src + 5) & 15, (dst + 7) & 15, 3);
            if (pulse_at > 0 && i == pulse_at + 1) driveStart(sel, 1'b0, src, dst, len);
            if (done_cyc > 0 && i == done_cyc + 1) begin
                busy_after = int'(bz);
                break;
            end
        end
    endtask

    task automatic checkTransfer(input string tag, input int lat, input int src, input int dst, input int len);
        checkOutput({tag, ".num_writes"}, wr_cyc.size(), len);
        for (int k = 0; k < len && k < wr_cyc.size(); k++) begin
            checkOutput($sformatf("%s.wr%0d_cycle", tag, k), wr_cyc[k], 1 + k + lat);
            checkOutput($sformatf("%s.wr%0d_addr", tag, k), wr_addr[k], (dst + k) & 15);
            checkOutput($sformatf("%s.wr%0d_data", tag, k), wr_data[k], 'hA0 + ((src + k) & 15));
        end
        for (int k = 0; k < rd_addr.size(); k++) begin
            checkOutput($sformatf("%s.rd%0d_addr", tag, k), rd_addr[k], (src + k) & 15);
        end
        checkOutput({tag, ".done_cycle"}, done_cyc, (len == 0) ? 1 : len + lat + 1);
        checkOutput({tag, ".done_pulses"}, done_count, 1);
        checkOutput({tag, ".busy_after"}, busy_after, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        driveStart(1, 1'b0, 0, 0, 0);
        driveStart(3, 1'b0, 0, 0, 0);
        repeat (3) @(negedge clk);

        checkOutput("reset.busy",     int'(if1.busy),     0);
        checkOutput("reset.done",     int'(if1.done_sig), 0);
        checkOutput("reset.rom_addr", int'(if1.rom_addr), 0);
        checkOutput("reset.write_en", int'(if1.write_en), 0);
        checkOutput("reset.ram_addr", int'(if1.ram_addr), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] basic copy, ROM_LAT=1");
        applyStimulus(1, 0, 0, 16, 0, 40);
        checkTransfer("basic", 1, 0, 0, 16);
        @(negedge clk);

        $display("[TB] wrap and offset");
        applyStimulus(1, 14, 3, 4, 0, 30);
        checkTransfer("wrap", 1, 14, 3, 4);
        @(negedge clk);

        $display("[TB] latency sweep, ROM_LAT=3");
        applyStimulus(3, 5, 9, 2, 0, 30);
        checkTransfer("lat3", 3, 5, 9, 2);
        @(negedge clk);

        $display("[TB] zero length");
        applyStimulus(1, 6, 6, 0, 0, 20);
        checkTransfer("zero", 1, 6, 6, 0);
        @(negedge clk);

        $display("[TB] start while busy is ignored");
        applyStimulus(1, 2, 10, 8, 3, 30);
        checkTransfer("ignore", 1, 2, 10, 8);
        @(negedge clk);

        $display("[TB] reset mid-transfer");
        driveStart(1, 1'b1, 0, 0, 16);
        @(posedge clk);
        @(negedge clk);
        driveStart(1, 1'b0, 0, 0, 16);
        repeat (3) @(negedge clk);
        checkOutput("midrst.pre_busy",  int'(if1.busy),     1);
        checkOutput("midrst.pre_write", int'(if1.write_en), 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst.write_en", int'(if1.write_en), 0);
        checkOutput("midrst.busy",     int'(if1.busy),     0);
        checkOutput("midrst.done",     int'(if1.done_sig), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midrst.idle_write", int'(if1.write_en), 0);
        applyStimulus(1, 4, 0, 16, 0, 40);
        checkTransfer("after_rst", 1, 4, 0, 16);
        @(negedge clk);

        $display("[TB] back-to-back");
        applyStimulus(1, 0, 8, 3, 0, 20);
        checkTransfer("b2b_first", 1, 0, 8, 3);
        applyStimulus(1, 5, 2, 6, 0, 20);
        checkTransfer("b2b_second", 1, 5, 2, 6);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/rom_ram_copy_engine.md
Name: rom_ram_copy_engine

Overview:
Parametrised ROM-to-RAM block copier and successor to the fixed 16-word ROM sequencer. On start, it issues one ROM read per cycle over a programmable source window. A ROM_LAT-deep alignment pipeline delays write_en and ram_addr so they line up with the returning ROM data. Sits between a synchronous ROM (external, latency ROM_LAT) and a RAM write port, with start/done handshake to the controlling FSM.

Parameters:
DATA_W, 8, ROM/RAM data width
ADDR_W, 4, ROM and RAM address width; address space 2^ADDR_W words
ROM_LAT, 1, ROM read latency in clocks, legal 1..4; also the depth of the alignment pipeline

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
start_sig  in  1  start request, sampled only in IDLE
src_base  in  ADDR_W  first ROM address, sampled with start_sig
dst_base  in  ADDR_W  first RAM address, sampled with start_sig
length  in  ADDR_W+1  word count, 0..2^ADDR_W, sampled with start_sig
busy  out  1  transfer in progress
done_sig  out  1  one-cycle completion pulse
rom_addr  out  ADDR_W  registered ROM read address
rom_data_in  in  DATA_W  ROM read data, valid ROM_LAT cycles after rom_addr
write_en  out  1  RAM write strobe, aligned with ram_data
ram_addr  out  ADDR_W  RAM write address, aligned with write_en
ram_data  out  DATA_W  direct pass-through of rom_data_in

Behaviour:
- Reset: state IDLE, busy=0, done_sig=0, rom_addr=0, write_en=0, ram_addr=0, all pipeline stages and counters cleared. Reset mid-transfer aborts immediately; no further writes.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE: start_sig=1 at edge T latches src_base, dst_base and length.
  - length>0: go to READ.
  - length=0: go to DONE; no reads, no writes.
- READ: entered at cycle T+1 with rom_addr=src_base and issue-valid=1. Each cycle, increment rom_addr and the dst counter modulo 2^ADDR_W (wrap 2^ADDR_W-1 -> 0 is legal). Decrement the remaining count. After the last issue, go to DRAIN.
- Issue-valid and the dst address enter a ROM_LAT-stage shift register. write_en and ram_addr are the final stage, so word k (k=0..length-1) is written at cycle T+1+k+ROM_LAT.
- DRAIN: wait until the pipeline is empty, i.e. the last write has occurred, then go to DONE.
- DONE: done_sig=1 for exactly one cycle, then IDLE.
  - length>0: done at cycle T+length+ROM_LAT+1.
  - length=0: done at cycle T+1.
- busy=1 in READ, DRAIN and DONE; busy=0 in IDLE. A new start is accepted on the first IDLE cycle after the done pulse.
- start_sig while busy is ignored. The latched parameters cannot change mid-transfer.
- ram_data = rom_data_in combinationally. It is meaningful only when write_en=1.
- rom_addr holds its last value outside READ. write_en is never high outside an issued word's slot.
- length > 2^ADDR_W is out of range; it is clamped to 2^ADDR_W.

Decomposition:
- Shared package holds:
  - state encoding (IDLE/READ/DRAIN/DONE, 2-bit);
  - ROM_LAT legal-range constants (ROM_LAT_MIN=1, ROM_LAT_MAX=4).
- One natural sub-module: align_pipe. It is a parametrised DEPTH x (1+ADDR_W) shift register with async reset, carrying valid and address. Instantiate it with DEPTH=ROM_LAT.

Test Plan:
- Basic copy (ROM_LAT=1):
  - Stimulus: ROM[i]=8'hA0+i; start at T with src=0, dst=0, len=16.
  - Required: write_en high at cycles T+2..T+17; ram_addr 0..15 matching ram_data A0..AF; done pulse at T+18; busy low at T+19.
- Wrap and offset:
  - Stimulus: src=14, dst=3, len=4.
  - Required: ROM reads 14,15,0,1; RAM writes to 3,4,5,6 with the corresponding data.
- Latency sweep:
  - Stimulus: ROM_LAT=3, len=2.
  - Required: writes at T+4 and T+5; done at T+6; no write_en at T+2 or T+3.
- Zero length and ignored start:
  - Stimulus: len=0.
  - Required: done at T+1, no write_en. Then during a len=8 transfer, pulse start with new bases; required: transfer unchanged, exactly 8 writes.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 during READ of a len=16 transfer.
  - Required: write_en, busy and done_sig go 0 asynchronously; after release, a fresh start completes normally.
- Back-to-back:
  - Stimulus: second start in the first IDLE cycle after done.
  - Required: accepted; correct writes; no extra done pulses.
